// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for the RV32I core: steps fetch/decode/execute/
// memory/write-back, handshakes with both memories, keeps performance
// counters and halts on SYSTEM, illegal opcodes or memory timeouts.
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE      | waiting for start
// FETCH     | instruction fetch, waits for imem_ready
// DECODE    | opcode class latched, illegal/SYSTEM detection
// EXECUTE   | ALU capture, branches resolve and retire here
// MEMORY    | data access, waits for dmem_ready; stores retire here
// WRITEBACK | register write and PC update
// HALT      | terminal until reset; counters frozen
module multicycle_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [6:0]       opcode,
    input  logic             bt,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_en,
    output logic             alu_en,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic             pc_en,
    output logic [1:0]       pc_sel,
    output logic [2:0]       state,
    output logic             halted,
    output logic             illegal,
    output logic             timeout_err,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retired_count
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_HALT      = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR,
        C_LUI, C_AUIPC, C_SYSTEM, C_ILLEGAL
    } cls_t;

    localparam int            WW      = $clog2(MEM_TIMEOUT + 1);
    // Wait-counter value seen during the last permitted low-ready cycle.
    localparam logic [WW-1:0] LP_LAST = WW'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LP_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t          r_state;
    state_t          w_next;
    cls_t            r_cls;
    cls_t            w_dec_cls;
    logic [WW-1:0]   r_wait;
    logic            w_wait_inc;
    logic            w_complete;
    logic            w_set_illegal;
    logic            w_set_timeout;
    logic            r_illegal;
    logic            r_timeout;
    logic [CNT_W-1:0] r_cycles;
    logic [CNT_W-1:0] r_retired;

    // Opcode class decode of the instruction register contents.
    always_comb begin
        case (opcode)
            7'b0110011: w_dec_cls = C_R;
            7'b0010011: w_dec_cls = C_I;
            7'b0000011: w_dec_cls = C_LOAD;
            7'b0100011: w_dec_cls = C_STORE;
            7'b1100011: w_dec_cls = C_BRANCH;
            7'b1101111: w_dec_cls = C_JAL;
            7'b1100111: w_dec_cls = C_JALR;
            7'b0110111: w_dec_cls = C_LUI;
            7'b0010111: w_dec_cls = C_AUIPC;
            7'b1110011: w_dec_cls = C_SYSTEM;
            default:    w_dec_cls = C_ILLEGAL;
        endcase
    end

    // Next-state and output decode; a ready in the last wait cycle wins over timeout.
    always_comb begin
        w_next        = r_state;
        w_wait_inc    = 1'b0;
        w_complete    = 1'b0;
        w_set_illegal = 1'b0;
        w_set_timeout = 1'b0;
        imem_req      = 1'b0;
        ir_en         = 1'b0;
        alu_en        = 1'b0;
        dmem_req      = 1'b0;
        dmem_we       = 1'b0;
        rf_we         = 1'b0;
        wb_sel        = 2'd0;
        pc_en         = 1'b0;
        pc_sel        = 2'd0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_en  = 1'b1;
                    w_next = S_DECODE;
                end else if (r_wait == LP_LAST) begin
                    w_next        = S_HALT;
                    w_set_timeout = 1'b1;
                end else begin
                    w_wait_inc = 1'b1;
                end
            end
            S_DECODE: begin
                case (w_dec_cls)
                    C_ILLEGAL: begin
                        w_next        = S_HALT;
                        w_set_illegal = 1'b1;
                    end
                    C_SYSTEM: w_next = S_HALT;
                    default:  w_next = S_EXECUTE;
                endcase
            end
            S_EXECUTE: begin
                alu_en = 1'b1;
                case (r_cls)
                    C_LOAD, C_STORE: w_next = S_MEMORY;
                    C_BRANCH: begin
                        pc_en      = 1'b1;
                        pc_sel     = {1'b0, bt};
                        w_complete = 1'b1;
                    end
                    default: w_next = S_WRITEBACK;
                endcase
            end
            S_MEMORY: begin
                dmem_req = 1'b1;
                dmem_we  = (r_cls == C_STORE);
                if (dmem_ready) begin
                    if (r_cls == C_STORE) begin
                        pc_en      = 1'b1;
                        w_complete = 1'b1;
                    end else begin
                        w_next = S_WRITEBACK;
                    end
                end else if (r_wait == LP_LAST) begin
                    w_next        = S_HALT;
                    w_set_timeout = 1'b1;
                end else begin
                    w_wait_inc = 1'b1;
                end
            end
            S_WRITEBACK: begin
                rf_we      = 1'b1;
                pc_en      = 1'b1;
                w_complete = 1'b1;
                case (r_cls)
                    C_LOAD:  wb_sel = 2'd1;
                    C_JAL:   begin wb_sel = 2'd2; pc_sel = 2'd2; end
                    C_JALR:  begin wb_sel = 2'd2; pc_sel = 2'd3; end
                    default: wb_sel = 2'd0;
                endcase
            end
            S_HALT: w_next = S_HALT;
            default: w_next = S_IDLE;
        endcase
        if (w_complete) w_next = stop ? S_IDLE : S_FETCH;
    end

    // State, class latch, wait counter and sticky error flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cls     <= C_R;
            r_wait    <= '0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) r_cls <= w_dec_cls;
            if (w_next != r_state)   r_wait <= '0;
            else if (w_wait_inc)     r_wait <= r_wait + WW'(1);
            if (w_set_illegal) r_illegal <= 1'b1;
            if (w_set_timeout) r_timeout <= 1'b1;
        end
    end

    // Performance counters; both wrap naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cycles  <= '0;
            r_retired <= '0;
        end else begin
            if (r_state != S_IDLE && r_state != S_HALT) r_cycles <= r_cycles + LP_ONE;
            if (w_complete) r_retired <= r_retired + LP_ONE;
        end
    end

    assign state         = r_state;
    assign halted        = (r_state == S_HALT);
    assign illegal       = r_illegal;
    assign timeout_err   = r_timeout;
    assign cycle_count   = r_cycles;
    assign retired_count = r_retired;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench: the driver pushes the expected per-cycle outputs into
// a queue, a negedge monitor pops and compares them with the DUT.
module tb_multicycle_sequencer;

    localparam int MT = 4;
    localparam int CW = 32;

    localparam int K_R = 0, K_I = 1, K_LOAD = 2, K_STORE = 3, K_BRANCH = 4,
                   K_JAL = 5, K_JALR = 6, K_LUI = 7, K_AUIPC = 8, K_SYS = 9, K_ILL = 10;

    logic          clk, reset, start, stop, bt, imem_ready, dmem_ready;
    logic [6:0]    opcode;
    logic          imem_req, ir_en, alu_en, dmem_req, dmem_we, rf_we, pc_en;
    logic [1:0]    wb_sel, pc_sel;
    logic [2:0]    state;
    logic          halted, illegal, timeout_err;
    logic [CW-1:0] cycle_count, retired_count;

    multicycle_sequencer #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .opcode(opcode),
        .bt(bt), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .ir_en(ir_en), .alu_en(alu_en), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .rf_we(rf_we), .wb_sel(wb_sel), .pc_en(pc_en),
        .pc_sel(pc_sel), .state(state), .halted(halted), .illegal(illegal),
        .timeout_err(timeout_err), .cycle_count(cycle_count),
        .retired_count(retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [16:0]   q_exp[$];
    logic [CW-1:0] m_cycles, m_retired;
    logic          m_ill, m_to;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int cls_of(input logic [6:0] op);
        case (op)
            7'b0110011: return K_R;
            7'b0010011: return K_I;
            7'b0000011: return K_LOAD;
            7'b0100011: return K_STORE;
            7'b1100011: return K_BRANCH;
            7'b1101111: return K_JAL;
            7'b1100111: return K_JALR;
            7'b0110111: return K_LUI;
            7'b0010111: return K_AUIPC;
            7'b1110011: return K_SYS;
            default:    return K_ILL;
        endcase
    endfunction

    // {state, halted, illegal, timeout_err, imem_req, ir_en, alu_en,
    //  dmem_req, dmem_we, rf_we, pc_en, wb_sel, pc_sel}
    function automatic logic [16:0] rec(input logic [2:0] st, input logic ireq, input logic iren,
                                        input logic alu, input logic dreq, input logic dwe,
                                        input logic rfwe, input logic pcen,
                                        input logic [1:0] wbs, input logic [1:0] pcs);
        return {st, (st == 3'd6), m_ill, m_to, ireq, iren, alu, dreq, dwe, rfwe, pcen, wbs, pcs};
    endfunction

    // Monitor: compares one queued expectation per cycle, then advances the counter model.
    always @(negedge clk) begin
        if (q_exp.size() > 0) begin
            logic [16:0] e;
            e = q_exp.pop_front();
            chk($sformatf("outs st%0d", e[16:14]),
                {state, halted, illegal, timeout_err, imem_req, ir_en, alu_en,
                 dmem_req, dmem_we, rf_we, pc_en, wb_sel, pc_sel}, e);
            chk("cycle_count", cycle_count, m_cycles);
            chk("retired_count", retired_count, m_retired);
            if (e[16:14] != 3'd0 && e[16:14] != 3'd6) m_cycles = m_cycles + 1;
            if (e[4]) m_retired = m_retired + 1;
        end
    end

    task automatic step(input logic [16:0] e);
        q_exp.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic noise();
        start      = 1'($urandom);
        stop       = 1'($urandom);
        bt         = 1'($urandom);
        imem_ready = 1'($urandom);
        dmem_ready = 1'($urandom);
        opcode     = 7'($urandom);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        #1;
        chk("rst state", state, 3'd0);
        chk("rst enables", {imem_req, ir_en, alu_en, dmem_req, dmem_we, rf_we, pc_en}, 7'd0);
        chk("rst sels", {wb_sel, pc_sel}, 4'd0);
        chk("rst flags", {halted, illegal, timeout_err}, 3'd0);
        chk("rst cycle_count", cycle_count, 0);
        chk("rst retired_count", retired_count, 0);
        m_cycles = '0; m_retired = '0; m_ill = 1'b0; m_to = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic idle_cycle(input logic st);
        noise();
        start = st;
        step(rec(3'd0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0));
    endtask

    task automatic halt_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            noise();
            step(rec(3'd6, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0));
        end
    endtask

    // Runs one instruction starting in FETCH; returns early if the FSM halts.
    task automatic do_instr(input logic [6:0] op, input logic b, input int iw, input int dw,
                            input logic stp);
        int c;
        logic [1:0] wbs, pcs;
        c = cls_of(op);
        for (int i = 0; i < iw; i++) begin
            noise();
            imem_ready = 1'b0;
            step(rec(3'd1, 1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0));
            if (i + 1 == MT) begin m_to = 1'b1; return; end
        end
        noise();
        imem_ready = 1'b1;
        step(rec(3'd1, 1, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0));
        noise();
        opcode = op;
        step(rec(3'd2, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0));
        if (c == K_ILL) begin m_ill = 1'b1; return; end
        if (c == K_SYS) return;
        noise();
        bt = b;
        if (c == K_BRANCH) begin
            stop = stp;
            step(rec(3'd3, 0, 0, 1, 0, 0, 0, 1, 2'd0, {1'b0, b}));
            return;
        end
        step(rec(3'd3, 0, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0));
        if (c == K_LOAD || c == K_STORE) begin
            for (int i = 0; i < dw; i++) begin
                noise();
                dmem_ready = 1'b0;
                step(rec(3'd4, 0, 0, 0, 1, (c == K_STORE), 0, 0, 2'd0, 2'd0));
                if (i + 1 == MT) begin m_to = 1'b1; return; end
            end
            noise();
            dmem_ready = 1'b1;
            if (c == K_STORE) begin
                stop = stp;
                step(rec(3'd4, 0, 0, 0, 1, 1, 0, 1, 2'd0, 2'd0));
                return;
            end
            step(rec(3'd4, 0, 0, 0, 1, 0, 0, 0, 2'd0, 2'd0));
        end
        wbs = (c == K_LOAD) ? 2'd1 : (c == K_JAL || c == K_JALR) ? 2'd2 : 2'd0;
        pcs = (c == K_JAL) ? 2'd2 : (c == K_JALR) ? 2'd3 : 2'd0;
        noise();
        stop = stp;
        step(rec(3'd5, 0, 0, 0, 0, 0, 1, 1, wbs, pcs));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; bt = 1'b0;
        imem_ready = 1'b0; dmem_ready = 1'b0; opcode = 7'd0;
        m_cycles = '0; m_retired = '0; m_ill = 1'b0; m_to = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Normal program: mix of classes, memory waits, then stop at a store.
        idle_cycle(1'b0);
        idle_cycle(1'b1);
        do_instr(7'b0110011, 0, 0, 0, 0);   // R
        do_instr(7'b0000011, 0, 1, 3, 0);   // LOAD, 3 dmem waits
        do_instr(7'b1100011, 1, 0, 0, 0);   // BRANCH taken
        do_instr(7'b1100011, 0, 2, 0, 0);   // BRANCH not taken
        do_instr(7'b0100011, 0, 0, 0, 0);   // STORE
        do_instr(7'b0010011, 0, 0, 0, 0);   // I
        do_instr(7'b0110111, 0, 0, 0, 0);   // LUI
        do_instr(7'b0010111, 0, 3, 0, 0);   // AUIPC, 3 imem waits
        do_instr(7'b1100111, 0, 0, 0, 0);   // JALR
        do_instr(7'b0100011, 0, 0, 3, 1);   // STORE, ready on last allowed cycle, stop
        idle_cycle(1'b0);
        idle_cycle(1'b1);
        do_instr(7'b0100011, 0, 0, 4, 0);   // STORE timeout
        halt_cycles(4);
        do_reset();

        // Retired counter wrap with JAL and stop.
        idle_cycle(1'b0);
        force dut.r_retired = {CW{1'b1}};
        #1;
        release dut.r_retired;
        m_retired = {CW{1'b1}};
        idle_cycle(1'b1);
        do_instr(7'b1101111, 0, 0, 0, 1);   // JAL
        idle_cycle(1'b0);
        chk("wrap retired_count", retired_count, 0);
        do_reset();

        // Illegal opcode halt.
        idle_cycle(1'b1);
        do_instr(7'b1111111, 0, 0, 0, 0);
        halt_cycles(4);
        do_reset();

        // SYSTEM halt without illegal flag.
        idle_cycle(1'b1);
        do_instr(7'b1110011, 0, 0, 0, 0);
        halt_cycles(2);
        do_reset();

        // Fetch timeout.
        idle_cycle(1'b1);
        do_instr(7'b0110011, 0, MT, 0, 0);
        halt_cycles(2);
        do_reset();

        // Reset mid-instruction restarts from IDLE.
        idle_cycle(1'b1);
        noise();
        imem_ready = 1'b1;
        step(rec(3'd1, 1, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0));
        noise();
        opcode = 7'b0000011;
        #2;
        do_reset();
        idle_cycle(1'b0);
        idle_cycle(1'b1);
        do_instr(7'b0110011, 0, 0, 0, 1);
        idle_cycle(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Multi-cycle control FSM for the single-issue RV32I core. It steps the datapath (program counter, instruction memory, decoder, ALU, data memory and write-back) through fetch, decode, execute, memory and write-back. It issues one-cycle enables and mux selects to each stage and handshakes with instruction and data memory. It also maintains cycle and retired-instruction counters and stops the core on ECALL/EBREAK, illegal opcodes or a memory timeout.

## Interface
Parameters:
- MEM_TIMEOUT, 16: maximum wait cycles for a memory ready before error halt (>=1).
- CNT_W, 32: width of the performance counters.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  level; leaves IDLE when 1.
- stop  input  1  level; sampled at instruction completion.
- opcode  input  7  instr[6:0] from the instruction register; valid in DECODE.
- bt  input  1  branch-taken from the ALU; valid in EXECUTE.
- imem_ready  input  1  instruction memory has data this cycle.
- dmem_ready  input  1  data memory has completed the access this cycle.
- imem_req  output  1  instruction fetch request.
- ir_en  output  1  load the instruction register.
- alu_en  output  1  ALU operand and result capture.
- dmem_req  output  1  data memory request.
- dmem_we  output  1  1 = store, 0 = load; meaningful only with dmem_req.
- rf_we  output  1  register-file write enable.
- wb_sel  output  2  write-back source: 0 = ALU, 1 = memory, 2 = PC+4.
- pc_en  output  1  PC update enable.
- pc_sel  output  2  next PC: 0 = PC+4, 1 = branch target, 2 = JAL target, 3 = JALR target.
- state  output  3  current state encoding.
- halted  output  1  FSM is in HALT.
- illegal  output  1  sticky; an illegal opcode caused the halt.
- timeout_err  output  1  sticky; a memory timeout caused the halt.
- cycle_count  output  CNT_W  count of cycles spent outside IDLE and HALT.
- retired_count  output  CNT_W  count of completed instructions.

## Operation
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, HALT=6. Code 7 is unreachable and must recover to IDLE.
- Outputs are a combinational decode of the state register and the latched opcode class. Any enable not listed for a state is 0.
- Opcode classes: R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111, SYSTEM 1110011. Every other value is ILLEGAL.
- IDLE: if start=1, go to FETCH; otherwise stay.
- FETCH: imem_req=1.
  - When imem_ready=1: ir_en=1 and go to DECODE.
  - The wait counter runs while imem_ready=0. After MEM_TIMEOUT wait cycles, go to HALT and set timeout_err.
- DECODE: latch the opcode class.
  - ILLEGAL: go to HALT and set illegal.
  - SYSTEM: go to HALT.
  - Otherwise: go to EXECUTE.
- EXECUTE: alu_en=1.
  - LOAD or STORE: go to MEMORY.
  - BRANCH: pc_en=1, pc_sel = bt ? 1 : 0, retire, then completion.
  - Otherwise: go to WRITEBACK.
- MEMORY: dmem_req=1 and dmem_we=(class==STORE). Hold both until dmem_ready=1.
  - STORE on ready: pc_en=1, pc_sel=0, retire, completion.
  - LOAD on ready: go to WRITEBACK.
  - Timeout behaves as in FETCH.
- WRITEBACK: rf_we=1, pc_en=1, retire, completion.
  - wb_sel: LOAD=1; JAL or JALR=2; others=0.
  - pc_sel: JAL=2; JALR=3; others=0.
- Completion: if stop=1, go to IDLE; otherwise go to FETCH.
- HALT: terminal. Leaves only on reset. Counters freeze.
- The wait counter clears on every state change. The count compared against MEM_TIMEOUT is the number of cycles with the ready signal low.
- retired_count increments by 1 on each retire cycle. cycle_count increments in every state except IDLE and HALT. Both wrap from all-ones to 0.

## Timing
- Reset (asynchronous, reset=0):
  - state = IDLE.
  - All enables, halted, illegal, timeout_err = 0.
  - wb_sel = pc_sel = 0.
  - Both counters = 0 and the wait counter = 0.
- Deasserting reset mid-instruction restarts from IDLE; no partial enables may be emitted.
- Cycle counts with zero memory wait:
  - R, I, LUI, AUIPC, JAL, JALR: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH: 3 cycles.
- Each memory wait cycle adds one cycle.
- pc_en is asserted exactly once per retired instruction. rf_we is never asserted for STORE or BRANCH.
- A ready asserted in the same cycle that the wait counter hits MEM_TIMEOUT counts as success; ready takes priority.
- start is ignored outside IDLE. stop is only sampled at completion.

## Test plan
- Reset, then start=1 with R-type 0110011 and immediate readies: state sequence 1,2,3,5,1. rf_we=1 and wb_sel=0 only in cycle 4. retired_count=1 and cycle_count=4.
- LOAD with dmem_ready delayed 3 cycles: dmem_req held high for 4 cycles with dmem_we=0. Then WRITEBACK with wb_sel=1. Total 8 cycles.
- BRANCH with bt=1: pc_en=1 and pc_sel=1 in EXECUTE, no rf_we, back to FETCH after 3 cycles. Repeat with bt=0: pc_sel=0.
- Opcode 1111111: HALT with illegal=1 and halted=1. Counters freeze. Any start toggling is ignored until reset=0.
- MEM_TIMEOUT=4, STORE with dmem_ready held 0: HALT and timeout_err=1 after 4 wait cycles. A ready arriving on the 4th wait cycle completes normally instead.
- Preload retired_count to all-ones (force), run one JAL: count wraps to 0, wb_sel=2, pc_sel=2. With stop=1 the FSM then returns to IDLE.
